// File: rtl/instruction_decoder_pkg.sv
// Shared ISA definitions for the 4-bit CPU instruction decoder: field positions,
// special opcodes and the decoded-output record.
package instruction_decoder_pkg;

  localparam int INS_W = 11;

  localparam int OPC_HI   = 10;
  localparam int OPC_LO   = 8;
  localparam int JMP_HI   = 7;
  localparam int JMP_LO   = 4;
  localparam int SEL_W_HI = 5;
  localparam int SEL_W_LO = 4;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;
  localparam int SEL_A_HI = 3;
  localparam int SEL_A_LO = 2;
  localparam int SEL_B_HI = 1;
  localparam int SEL_B_LO = 0;

  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_NOP    = 3'b011;

  typedef struct packed {
    logic       sel_data;
    logic       write_en;
    logic       alu_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_w;
    logic [3:0] imm;
    logic [3:0] jmp;
    logic       is_branch;
    logic       is_nop;
  } dec_t;

  // Only branch and no-op leave the register file untouched.
  function automatic logic calc_write_en(input logic [2:0] opc);
    return (opc[2] | ~opc[1] | ~opc[0]) & (~opc[2] | opc[1] | opc[0]);
  endfunction

endpackage

// File: rtl/instruction_decoder_ins_dec_core.sv
// Purely combinational instruction slicer: splits the word into control bits and
// operand fields; overlapping views (SEL_A/SEL_B vs IMM, SEL_W vs JMP) are all driven.
module ins_dec_core
  import instruction_decoder_pkg::*;
(
  input  logic [INS_W-1:0] ins_i,
  output dec_t             dec_o
);

  logic [2:0] opc_s;

  assign opc_s = ins_i[OPC_HI:OPC_LO];

  // Slice fields and derive opcode-dependent flags
  always_comb begin
    dec_o           = '0;
    dec_o.sel_data  = ins_i[OPC_HI-1];
    dec_o.alu_op    = ins_i[OPC_LO];
    dec_o.write_en  = calc_write_en(opc_s);
    dec_o.sel_a     = ins_i[SEL_A_HI:SEL_A_LO];
    dec_o.sel_b     = ins_i[SEL_B_HI:SEL_B_LO];
    dec_o.sel_w     = ins_i[SEL_W_HI:SEL_W_LO];
    dec_o.imm       = ins_i[IMM_HI:IMM_LO];
    dec_o.jmp       = ins_i[JMP_HI:JMP_LO];
    dec_o.is_branch = (opc_s == OP_BRANCH) ? 1'b1 : 1'b0;
    dec_o.is_nop    = (opc_s == OP_NOP) ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/instruction_decoder.sv
// Registered decode stage: one-cycle latency, fields hold on idle cycles while the
// action strobes (write_en, is_branch, is_nop, out_valid) drop to zero.
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] INS,
  input  logic             ins_valid,
  output logic             out_valid,
  output logic             sel_data,
  output logic             write_en,
  output logic             alu_op,
  output logic [1:0]       SEL_A,
  output logic [1:0]       SEL_B,
  output logic [1:0]       SEL_W,
  output logic [3:0]       IMM,
  output logic [3:0]       JMP,
  output logic             is_branch,
  output logic             is_nop
);

  dec_t dec_c_s;
  dec_t dec_d;
  dec_t dec_q;
  logic valid_d;
  logic valid_q;

  ins_dec_core u_core (
    .ins_i (INS),
    .dec_o (dec_c_s)
  );

  // Next-state: load on valid, otherwise hold fields and squash strobes
  always_comb begin
    dec_d   = dec_q;
    valid_d = 1'b0;
    if (ins_valid) begin
      dec_d   = dec_c_s;
      valid_d = 1'b1;
    end else begin
      dec_d.write_en  = 1'b0;
      dec_d.is_branch = 1'b0;
      dec_d.is_nop    = 1'b0;
      valid_d         = 1'b0;
    end
  end

  // Output register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign sel_data  = dec_q.sel_data;
  assign write_en  = dec_q.write_en;
  assign alu_op    = dec_q.alu_op;
  assign SEL_A     = dec_q.sel_a;
  assign SEL_B     = dec_q.sel_b;
  assign SEL_W     = dec_q.sel_w;
  assign IMM       = dec_q.imm;
  assign JMP       = dec_q.jmp;
  assign is_branch = dec_q.is_branch;
  assign is_nop    = dec_q.is_nop;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed test-plan steps with literal
// expectations, then random traffic checked against an arithmetic reference model.
module tb_instruction_decoder;

  logic        clk;
  logic        rst;
  logic [10:0] INS;
  logic        ins_valid;
  logic        out_valid, sel_data, write_en, alu_op, is_branch, is_nop;
  logic [1:0]  SEL_A, SEL_B, SEL_W;
  logic [3:0]  IMM, JMP;

  int tests;
  int fails;

  // reference model state
  int m_valid, m_we, m_br, m_nop;
  int m_sd, m_alu, m_a, m_b, m_w, m_imm, m_jmp;

  instruction_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .INS       (INS),
    .ins_valid (ins_valid),
    .out_valid (out_valid),
    .sel_data  (sel_data),
    .write_en  (write_en),
    .alu_op    (alu_op),
    .SEL_A     (SEL_A),
    .SEL_B     (SEL_B),
    .SEL_W     (SEL_W),
    .IMM       (IMM),
    .JMP       (JMP),
    .is_branch (is_branch),
    .is_nop    (is_nop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] obs_vec();
    return {out_valid, sel_data, write_en, alu_op, SEL_A, SEL_B, SEL_W, IMM, JMP, is_branch, is_nop};
  endfunction

  function automatic logic [19:0] model_vec();
    logic [19:0] v;
    v = {m_valid[0], m_sd[0], m_we[0], m_alu[0], m_a[1:0], m_b[1:0], m_w[1:0],
         m_imm[3:0], m_jmp[3:0], m_br[0], m_nop[0]};
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_br = 0; m_nop = 0;
    m_sd = 0; m_alu = 0; m_a = 0; m_b = 0; m_w = 0; m_imm = 0; m_jmp = 0;
  endtask

  task automatic model_step(input int ins, input bit v, input bit r);
    int opc;
    if (r) begin
      model_reset();
    end else if (v) begin
      opc     = ins / 256;
      m_valid = 1;
      m_sd    = (ins / 512) % 2;
      m_alu   = (ins / 256) % 2;
      m_a     = (ins / 4) % 4;
      m_b     = ins % 4;
      m_w     = (ins / 16) % 4;
      m_imm   = ins % 16;
      m_jmp   = (ins / 16) % 16;
      m_we    = (opc == 3 || opc == 4) ? 0 : 1;
      m_br    = (opc == 4) ? 1 : 0;
      m_nop   = (opc == 3) ? 1 : 0;
    end else begin
      m_valid = 0; m_we = 0; m_br = 0; m_nop = 0;
    end
  endtask

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] got;
    got = obs_vec();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
    end
  endtask

  // drive one cycle, advance model, compare against the model
  task automatic step(input string tag, input logic [10:0] ins, input logic v, input logic r);
    @(negedge clk);
    INS = ins; ins_valid = v; rst = r;
    @(posedge clk);
    #1;
    model_step(int'(ins), v, r);
    check(tag, model_vec());
  endtask

  initial begin
    logic [10:0] rins;
    logic        rv, rr;
    tests = 0; fails = 0;
    model_reset();
    rst = 1'b1; INS = 11'h000; ins_valid = 1'b0;

    step("reset_7ff", 11'h7FF, 1'b1, 1'b1);
    check("reset_lit", 20'h00000);

    step("zeros", 11'b000_0000_0000, 1'b1, 1'b0);
    check("zeros_lit", {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0});

    step("ones", 11'b111_1111_1111, 1'b1, 1'b0);
    check("ones_lit", {1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 4'hF, 4'hF, 1'b0, 1'b0});

    step("gate_idle", 11'h000, 1'b0, 1'b0);
    check("gate_lit", {1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 4'hF, 4'hF, 1'b0, 1'b0});

    step("alt_a", 11'b101_0101_0101, 1'b1, 1'b0);
    check("alt_a_lit", {1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 4'h5, 4'h5, 1'b0, 1'b0});

    step("alt_b", 11'b010_1010_1010, 1'b1, 1'b0);
    check("alt_b_lit", {1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 4'hA, 4'hA, 1'b0, 1'b0});

    step("branch", 11'b100_0000_0000, 1'b1, 1'b0);
    check("branch_lit", {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0});

    step("nop", 11'b011_0000_0000, 1'b1, 1'b0);
    check("nop_lit", {1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1});

    // reset mid-stream discards the instruction presented with it
    step("mid_valid", 11'h6C3, 1'b1, 1'b0);
    step("mid_reset", 11'h2B7, 1'b1, 1'b1);
    step("after_rst", 11'h000, 1'b0, 1'b0);
    step("resume", 11'h1E4, 1'b1, 1'b0);

    for (int op = 0; op < 8; op++) begin
      rins = {op[2:0], 8'($urandom_range(0, 255))};
      step($sformatf("opc_%0d", op), rins, 1'b1, 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      rins = 11'($urandom_range(0, 2047));
      rv   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      rr   = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
      step("random", rins, rv, rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
